// File: rtl/tpsram_pkg.sv
// Shared types and lane helpers for the tpsram_bank two-port SRAM.
// Helpers work on MAX_DW-wide vectors; callers zero-extend inputs and truncate results with casts.
package tpsram_pkg;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam int MAX_DW = 256;
    localparam int MAX_NB = MAX_DW / 8;

    function automatic logic [MAX_DW-1:0] byte_merge(
        input logic [MAX_DW-1:0] old_data,
        input logic [MAX_DW-1:0] new_data,
        input logic [MAX_NB-1:0] be
    );
        logic [MAX_DW-1:0] merged;
        merged = old_data;
        for (int i = 0; i < MAX_NB; i++) begin
            if (be[i]) merged[8*i +: 8] = new_data[8*i +: 8];
        end
        return merged;
    endfunction

    // Even parity: the stored bit makes each 9-bit lane carry an even number of ones.
    function automatic logic [MAX_NB-1:0] byte_parity(input logic [MAX_DW-1:0] data);
        logic [MAX_NB-1:0] par;
        for (int i = 0; i < MAX_NB; i++) begin
            par[i] = ^data[8*i +: 8];
        end
        return par;
    endfunction

endpackage

// File: rtl/tpsram_bank_if.sv
// Write/read port bundle of tpsram_bank; PERR exists only with TPSRAM_BANK_PARITY_EN.
// Reads: REN is a request, RVALID a single-cycle pulse; there is no backpressure.
interface tpsram_bank_if #(
    parameter int AW = 12,
    parameter int DW = 32
);
    localparam int NB = DW / 8;

    logic          WEN;
    logic [AW-1:0] WADDR;
    logic [DW-1:0] WD;
    logic [NB-1:0] WBE;
    logic          REN;
    logic [AW-1:0] RADDR;
    logic [DW-1:0] RD;
    logic          RVALID;
    logic          INIT_DONE;
`ifdef TPSRAM_BANK_PARITY_EN
    logic          PERR;

    modport master (
        output WEN, WADDR, WD, WBE, REN, RADDR,
        input  RD, RVALID, INIT_DONE, PERR
    );
    modport slave (
        input  WEN, WADDR, WD, WBE, REN, RADDR,
        output RD, RVALID, INIT_DONE, PERR
    );
`else
    modport master (
        output WEN, WADDR, WD, WBE, REN, RADDR,
        input  RD, RVALID, INIT_DONE
    );
    modport slave (
        input  WEN, WADDR, WD, WBE, REN, RADDR,
        output RD, RVALID, INIT_DONE
    );
`endif

endinterface

// File: rtl/tpsram_array.sv
// Raw 1W/1R storage with per-lane write enables and a registered read port.
// Read returns pre-write contents on an address collision; no reset, so it can be swapped for a macro.
module tpsram_array #(
    parameter int AW    = 12,
    parameter int LANES = 4,
    parameter int LW    = 8
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [LANES*LW-1:0]   i_wdata,
    input  logic [LANES-1:0]      i_wbe,
    input  logic                  i_re,
    input  logic [AW-1:0]         i_raddr,
    output logic [LANES*LW-1:0]   o_rdata
);

    logic [LANES*LW-1:0] r_mem [2**AW];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (i_wbe[i]) r_mem[i_waddr][i*LW +: LW] <= i_wdata[i*LW +: LW];
            end
        end
        if (i_re) o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/tpsram_bank.sv
// Parametrised 1W/1R SRAM bank: post-reset zero fill, byte enables, write-first forwarding,
// optional output register (OUT_REG). Define TPSRAM_BANK_PARITY_EN for per-lane parity and PERR.
module tpsram_bank
    import tpsram_pkg::*;
#(
    parameter int AW      = 12,
    parameter int DW      = 32,
    parameter int OUT_REG = 0
) (
    input  logic           CLK,
    input  logic           RESETN,
    tpsram_bank_if.slave   bus
);

    localparam int NB = DW / 8;
`ifdef TPSRAM_BANK_PARITY_EN
    localparam int LW = 9;
`else
    localparam int LW = 8;
`endif
    localparam int ADW = NB * LW;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_cnt;

    logic            w_arr_we;
    logic [AW-1:0]   w_arr_waddr;
    logic [NB-1:0]   w_arr_wbe;
    logic [ADW-1:0]  w_arr_wd;
    logic [ADW-1:0]  w_lane_wd;
    logic [ADW-1:0]  w_arr_rd;
    logic            w_rd_acc;
    logic            w_fwd_hit;

    logic            r_v1;
    logic            r_have;
    logic [NB-1:0]   r_fwd_be;
    logic [DW-1:0]   r_fwd_wd;
    logic [DW-1:0]   w_old_data;
    logic [DW-1:0]   w_merged;
    logic [DW-1:0]   w_rd1;
    logic            w_err1;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_INIT) r_cnt <= r_cnt + AW'(1);
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT:  if (r_cnt == '1) w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_INIT;
        endcase
    end

    // ---------------- FSM: outputs (array port steering) ----------------
    always_comb begin
        w_arr_we    = 1'b0;
        w_arr_waddr = '0;
        w_arr_wbe   = '0;
        w_arr_wd    = '0;
        w_rd_acc    = 1'b0;
        w_fwd_hit   = 1'b0;
        case (r_state)
            S_INIT: begin
                w_arr_we    = 1'b1;
                w_arr_waddr = r_cnt;
                w_arr_wbe   = '1;
            end
            S_RUN: begin
                w_arr_we    = bus.WEN;
                w_arr_waddr = bus.WADDR;
                w_arr_wbe   = bus.WBE;
                w_arr_wd    = w_lane_wd;
                w_rd_acc    = bus.REN;
                w_fwd_hit   = bus.WEN && (bus.WADDR == bus.RADDR);
            end
            default: ;
        endcase
    end

    assign bus.INIT_DONE = (r_state == S_RUN);

`ifdef TPSRAM_BANK_PARITY_EN
    logic [NB-1:0] w_wpar;
    logic [NB-1:0] w_old_par;
    logic [NB-1:0] w_calc_par;
    assign w_wpar = NB'(byte_parity(MAX_DW'(bus.WD)));
`endif

    always_comb begin
        w_lane_wd = '0;
        for (int i = 0; i < NB; i++) begin
            w_lane_wd[i*LW +: 8] = bus.WD[8*i +: 8];
`ifdef TPSRAM_BANK_PARITY_EN
            w_lane_wd[i*LW + 8]  = w_wpar[i];
`endif
        end
    end

    tpsram_array #(
        .AW    (AW),
        .LANES (NB),
        .LW    (LW)
    ) u_array (
        .i_clk   (CLK),
        .i_we    (w_arr_we),
        .i_waddr (w_arr_waddr),
        .i_wdata (w_arr_wd),
        .i_wbe   (w_arr_wbe),
        .i_re    (w_rd_acc),
        .i_raddr (bus.RADDR),
        .o_rdata (w_arr_rd)
    );

    // Forwarding lanes are captured alongside the array read so RD holds between reads.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_v1     <= 1'b0;
            r_have   <= 1'b0;
            r_fwd_be <= '0;
            r_fwd_wd <= '0;
        end else begin
            r_v1 <= w_rd_acc;
            if (w_rd_acc) begin
                r_have   <= 1'b1;
                r_fwd_be <= w_fwd_hit ? bus.WBE : '0;
                r_fwd_wd <= bus.WD;
            end
        end
    end

    always_comb begin
        w_old_data = '0;
        for (int i = 0; i < NB; i++) begin
            w_old_data[8*i +: 8] = w_arr_rd[i*LW +: 8];
        end
    end

`ifdef TPSRAM_BANK_PARITY_EN
    always_comb begin
        w_old_par = '0;
        for (int i = 0; i < NB; i++) begin
            w_old_par[i] = w_arr_rd[i*LW + 8];
        end
    end
    assign w_calc_par = NB'(byte_parity(MAX_DW'(w_old_data)));
    assign w_err1     = r_v1 && |((w_calc_par ^ w_old_par) & ~r_fwd_be);
`else
    assign w_err1 = 1'b0;
`endif

    assign w_merged = DW'(byte_merge(MAX_DW'(w_old_data), MAX_DW'(r_fwd_wd), MAX_NB'(r_fwd_be)));
    // The array output register has no reset, so RD is forced to 0 until the first read lands.
    assign w_rd1    = r_have ? w_merged : '0;

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DW-1:0] r_rd2;
            logic          r_v2;
            logic          r_perr2;
            always_ff @(posedge CLK or negedge RESETN) begin
                if (!RESETN) begin
                    r_rd2   <= '0;
                    r_v2    <= 1'b0;
                    r_perr2 <= 1'b0;
                end else begin
                    r_v2    <= r_v1;
                    r_perr2 <= w_err1;
                    if (r_v1) r_rd2 <= w_rd1;
                end
            end
            assign bus.RD     = r_rd2;
            assign bus.RVALID = r_v2;
`ifdef TPSRAM_BANK_PARITY_EN
            assign bus.PERR   = r_perr2;
`endif
        end else begin : g_noreg
            logic w_perr_unused;
            assign w_perr_unused = w_err1;
            assign bus.RD     = w_rd1;
            assign bus.RVALID = r_v1;
`ifdef TPSRAM_BANK_PARITY_EN
            assign bus.PERR   = w_perr_unused;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_tpsram_bank.sv
// Directed bench for tpsram_bank (AW=4, DW=32): fill, byte writes, collisions, streaming, resets.
// The parity scenario is compiled only when TPSRAM_BANK_PARITY_EN is defined.
module tb_tpsram_bank;

    localparam int AW      = 4;
    localparam int DW      = 32;
    localparam int NB      = DW / 8;
    localparam int OUT_REG = 0;
    localparam int LAT     = OUT_REG + 1;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    tpsram_bank_if #(.AW(AW), .DW(DW)) bus ();

    tpsram_bank #(.AW(AW), .DW(DW), .OUT_REG(OUT_REG)) dut (
        .CLK    (clk),
        .RESETN (rst_n),
        .bus    (bus)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.WEN   = 1'b0;
        bus.WADDR = '0;
        bus.WD    = '0;
        bus.WBE   = '0;
        bus.REN   = 1'b0;
        bus.RADDR = '0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
        bus.WEN   = 1'b1;
        bus.WADDR = a;
        bus.WD    = d;
        bus.WBE   = be;
        step();
        bus.WEN   = 1'b0;
        bus.WBE   = '0;
    endtask

    // Issues one read and checks the RVALID pulse, data, and that RD holds afterwards.
    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
        bus.REN   = 1'b1;
        bus.RADDR = a;
        step();
        bus.REN   = 1'b0;
        for (int c = 1; c < LAT; c++) step();
        checks++;
        if (bus.RVALID !== 1'b1) begin
            errors++;
            $display("FAIL %s rvalid addr %0d: got %b expected 1", name, a, bus.RVALID);
        end
        checks++;
        if (bus.RD !== exp) begin
            errors++;
            $display("FAIL %s rd addr %0d: got %h expected %h", name, a, bus.RD, exp);
        end
        step();
        checks++;
        if (bus.RVALID !== 1'b0) begin
            errors++;
            $display("FAIL %s rvalid_pulse addr %0d: got %b expected 0", name, a, bus.RVALID);
        end
        checks++;
        if (bus.RD !== exp) begin
            errors++;
            $display("FAIL %s rd_hold addr %0d: got %h expected %h", name, a, bus.RD, exp);
        end
    endtask

    // Releases reset and checks the 16-cycle fill with REN held high.
    task automatic release_and_fill(input string name);
        bus.REN = 1'b1;
        rst_n   = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            bus.RADDR = AW'(c);
            step();
            checks++;
            if (bus.RVALID !== 1'b0) begin
                errors++;
                $display("FAIL %s rvalid_during_fill cycle %0d: got %b expected 0", name, c, bus.RVALID);
            end
            checks++;
            if (bus.INIT_DONE !== (c == 16)) begin
                errors++;
                $display("FAIL %s init_done cycle %0d: got %b expected %b", name, c, bus.INIT_DONE, (c == 16));
            end
        end
        bus.REN = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        rst_n   = 1'b0;
        bus.REN = 1'b1;
        repeat (3) step();
        checks++;
        if (bus.RD !== '0) begin
            errors++;
            $display("FAIL reset rd: got %h expected 0", bus.RD);
        end
        checks++;
        if (bus.RVALID !== 1'b0) begin
            errors++;
            $display("FAIL reset rvalid: got %b expected 0", bus.RVALID);
        end
        checks++;
        if (bus.INIT_DONE !== 1'b0) begin
            errors++;
            $display("FAIL reset init_done: got %b expected 0", bus.INIT_DONE);
        end
        release_and_fill("fill");
        for (int a = 0; a < 16; a++) do_read(AW'(a), 32'h0, "zero_fill");
    endtask

    task automatic test_byte_write();
        do_write(4'd3, 32'hAABBCCDD, 4'b1111);
        do_write(4'd3, 32'h11223344, 4'b0101);
        do_read(4'd3, 32'hAA22CC44, "byte_write");
        do_write(4'd3, 32'h99887766, 4'b0000);
        do_read(4'd3, 32'hAA22CC44, "wbe_zero_noop");
        do_write(4'd15, 32'h0BADF00D, 4'b1000);
        do_read(4'd15, 32'h0B000000, "top_lane_only");
    endtask

    task automatic test_collision();
        do_write(4'd5, 32'h12345678, 4'b1111);
        bus.WEN   = 1'b1;
        bus.WADDR = 4'd5;
        bus.WD    = 32'hFFFFFFFF;
        bus.WBE   = 4'b1100;
        bus.REN   = 1'b1;
        bus.RADDR = 4'd5;
        step();
        idle_inputs();
        for (int c = 1; c < LAT; c++) step();
        checks++;
        if (bus.RVALID !== 1'b1) begin
            errors++;
            $display("FAIL collision rvalid: got %b expected 1", bus.RVALID);
        end
        checks++;
        if (bus.RD !== 32'hFFFF5678) begin
            errors++;
            $display("FAIL collision rd: got %h expected ffff5678", bus.RD);
        end
        step();
        do_read(4'd5, 32'hFFFF5678, "collision_after");
        // Different addresses in the same cycle must not interact.
        bus.WEN   = 1'b1;
        bus.WADDR = 4'd6;
        bus.WD    = 32'hCAFEF00D;
        bus.WBE   = 4'b1111;
        bus.REN   = 1'b1;
        bus.RADDR = 4'd5;
        step();
        idle_inputs();
        for (int c = 1; c < LAT; c++) step();
        checks++;
        if (bus.RD !== 32'hFFFF5678) begin
            errors++;
            $display("FAIL independent rd: got %h expected ffff5678", bus.RD);
        end
        step();
        do_read(4'd6, 32'hCAFEF00D, "independent_write");
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp;
        int idx;
        for (int i = 0; i < 8; i++) do_write(AW'(i), 32'h100 + i, 4'b1111);
        for (int k = 0; k < 8 + LAT; k++) begin
            bus.REN   = (k < 8);
            bus.RADDR = AW'(k);
            step();
            idx = k - (LAT - 1);
            checks++;
            if (bus.RVALID !== (idx >= 0 && idx < 8)) begin
                errors++;
                $display("FAIL stream rvalid step %0d: got %b expected %b", k, bus.RVALID, (idx >= 0 && idx < 8));
            end
            if (idx >= 0 && idx < 8) begin
                exp = 32'h100 + idx;
                checks++;
                if (bus.RD !== exp) begin
                    errors++;
                    $display("FAIL stream rd step %0d: got %h expected %h", k, bus.RD, exp);
                end
            end
        end
        bus.REN = 1'b0;
    endtask

    task automatic test_mid_run_reset();
        do_write(4'd10, 32'h5A5A5A5A, 4'b1111);
        bus.REN   = 1'b1;
        bus.RADDR = 4'd10;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.INIT_DONE !== 1'b0) begin
            errors++;
            $display("FAIL midreset init_done: got %b expected 0", bus.INIT_DONE);
        end
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (bus.RVALID !== 1'b0) begin
                errors++;
                $display("FAIL midreset rvalid cycle %0d: got %b expected 0", c, bus.RVALID);
            end
        end
        checks++;
        if (bus.RD !== '0) begin
            errors++;
            $display("FAIL midreset rd: got %h expected 0", bus.RD);
        end
        release_and_fill("refill");
        do_read(4'd10, 32'h0, "refill_addr10");
        do_read(4'd3, 32'h0, "refill_addr3");
        do_read(4'd7, 32'h0, "refill_addr7");
    endtask

`ifdef TPSRAM_BANK_PARITY_EN
    task automatic test_parity();
        do_write(4'd7, 32'h01020304, 4'b1111);
        do_write(4'd8, 32'h0F0F0F0F, 4'b1111);
        dut.u_array.r_mem[7][2*9+8] = ~dut.u_array.r_mem[7][2*9+8];
        bus.REN   = 1'b1;
        bus.RADDR = 4'd7;
        step();
        bus.REN   = 1'b0;
        for (int c = 1; c < LAT; c++) step();
        checks++;
        if (bus.RVALID !== 1'b1 || bus.PERR !== 1'b1) begin
            errors++;
            $display("FAIL parity_err: got rvalid %b perr %b expected 1 1", bus.RVALID, bus.PERR);
        end
        step();
        checks++;
        if (bus.PERR !== 1'b0) begin
            errors++;
            $display("FAIL parity_pulse: got %b expected 0", bus.PERR);
        end
        bus.REN   = 1'b1;
        bus.RADDR = 4'd8;
        step();
        bus.REN   = 1'b0;
        for (int c = 1; c < LAT; c++) step();
        checks++;
        if (bus.RVALID !== 1'b1 || bus.PERR !== 1'b0) begin
            errors++;
            $display("FAIL parity_clean: got rvalid %b perr %b expected 1 0", bus.RVALID, bus.PERR);
        end
        step();
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle_inputs();
        #1;
        test_reset();
        test_byte_write();
        test_collision();
        test_back_to_back();
`ifdef TPSRAM_BANK_PARITY_EN
        test_parity();
`endif
        test_mid_run_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
